// File: rtl/render_sequencer.sv
// Per-frame render controller: clears the 160x120 screen, pulses move, runs the
// platform then ball drawers, and forwards their clipped writes to one VGA port.
module render_sequencer #(
   parameter int unsigned FRAME_DIV = 833333,
   parameter int unsigned SCREEN_W  = 160,
   parameter int unsigned SCREEN_H  = 120,
   parameter logic [2:0]  BG_COLOUR = 3'b000,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [9:0] p_x,
   input  logic [9:0] p_y,
   input  logic [2:0] p_colour,
   input  logic       p_wren,
   input  logic       p_done,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   input  logic [2:0] b_colour,
   input  logic       b_wren,
   input  logic       b_done,
   output logic       move_en,
   output logic       p_draw,
   output logic       b_draw,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       frame_done,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int unsigned FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int unsigned WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      MOVE    = 3'd2,
      P_START = 3'd3,
      P_WAIT  = 3'd4,
      B_START = 3'd5,
      B_WAIT  = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t          state;
   logic [FC_W-1:0] fc;
   logic [7:0]      cx;
   logic [6:0]      cy;
   logic [WC_W-1:0] wc;

   logic tick;
   logic row_last;
   logic clear_last;
   logic wait_expired;
   logic p_hit;
   logic b_hit;

   assign tick         = (fc == FC_W'(FRAME_DIV - 1));
   assign row_last     = (cx == 8'(SCREEN_W - 1));
   assign clear_last   = row_last && (cy == 7'(SCREEN_H - 1));
   assign wait_expired = (wc == WC_W'(TIMEOUT - 1));

   // A drawer write survives only if requested and inside the visible area
   assign p_hit = p_wren && (p_x < 10'(SCREEN_W)) && (p_y < 10'(SCREEN_H));
   assign b_hit = b_wren && (b_x < 10'(SCREEN_W)) && (b_y < 10'(SCREEN_H));

   // Free-running frame timebase, independent of go
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fc <= '0;
      end else if (tick) begin
         fc <= '0;
      end else begin
         fc <= fc + FC_W'(1);
      end
   end

   // Sequencer; every output is set on the edge that enters the cycle it belongs to
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cx          <= '0;
         cy          <= '0;
         wc          <= '0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
         vga_plot    <= 1'b0;
         move_en     <= 1'b0;
         p_draw      <= 1'b0;
         b_draw      <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         move_en    <= 1'b0;
         p_draw     <= 1'b0;
         b_draw     <= 1'b0;
         frame_done <= 1'b0;
         vga_plot   <= 1'b0;

         // A tick that cannot start a frame is dropped and flagged
         if (tick && (state != IDLE)) begin
            err_overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (tick && go) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cx    <= '0;
                  cy    <= '0;
               end
            end

            CLEAR: begin
               vga_x      <= cx;
               vga_y      <= cy;
               vga_colour <= BG_COLOUR;
               vga_plot   <= 1'b1;
               if (clear_last) begin
                  state   <= MOVE;
                  move_en <= 1'b1;
                  cx      <= '0;
                  cy      <= '0;
               end else if (row_last) begin
                  cx <= '0;
                  cy <= cy + 7'd1;
               end else begin
                  cx <= cx + 8'd1;
               end
            end

            MOVE: begin
               state  <= P_START;
               p_draw <= 1'b1;
            end

            P_START: begin
               state <= P_WAIT;
               wc    <= '0;
            end

            P_WAIT: begin
               if (p_hit) begin
                  vga_x      <= p_x[7:0];
                  vga_y      <= p_y[6:0];
                  vga_colour <= p_colour;
                  vga_plot   <= 1'b1;
               end
               if (p_done || wait_expired) begin
                  state  <= B_START;
                  b_draw <= 1'b1;
                  if (!p_done) begin
                     err_timeout <= 1'b1;
                  end
               end else begin
                  wc <= wc + WC_W'(1);
               end
            end

            B_START: begin
               state <= B_WAIT;
               wc    <= '0;
            end

            B_WAIT: begin
               if (b_hit) begin
                  vga_x      <= b_x[7:0];
                  vga_y      <= b_y[6:0];
                  vga_colour <= b_colour;
                  vga_plot   <= 1'b1;
               end
               if (b_done || wait_expired) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                  if (!b_done) begin
                     err_timeout <= 1'b1;
                  end
               end else begin
                  wc <= wc + WC_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer: randomized drawer traffic against a per-cycle
// expectation built from frame-level timing arithmetic.
module tb_render_sequencer;

   localparam int FD        = 19210;
   localparam int TO        = 16;
   localparam int SW        = 160;
   localparam int SH        = 120;
   localparam int NCLR      = SW * SH;
   localparam int MAXC      = 48200;
   localparam int NA        = 48102;
   localparam int NB        = 38500;
   localparam int MAX_FAILS = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       go;
   logic [9:0] p_x, p_y, b_x, b_y;
   logic [2:0] p_colour, b_colour;
   logic       p_wren, p_done, b_wren, b_done;
   logic       move_en, p_draw, b_draw;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot, busy, frame_done, err_timeout, err_overrun;

   int n_vec = 0;
   int n_bad = 0;

   // Stimulus per cycle
   bit       a_go [MAXC];
   bit [9:0] a_px [MAXC], a_py [MAXC], a_bx [MAXC], a_by [MAXC];
   bit [2:0] a_pc [MAXC], a_bc [MAXC];
   bit       a_pw [MAXC], a_pd [MAXC], a_bw [MAXC], a_bd [MAXC];

   // Expected outputs per cycle
   bit       e_plot [MAXC], e_move [MAXC], e_pdraw [MAXC], e_bdraw [MAXC];
   bit       e_fdone [MAXC], e_busy [MAXC], eto_ev [MAXC], e_eto [MAXC], e_eov [MAXC];
   bit [7:0] e_x [MAXC];
   bit [6:0] e_y [MAXC];
   bit [2:0] e_col [MAXC];

   render_sequencer #(
      .FRAME_DIV (FD),
      .SCREEN_W  (SW),
      .SCREEN_H  (SH),
      .BG_COLOUR (3'b000),
      .TIMEOUT   (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go),
      .p_x         (p_x),
      .p_y         (p_y),
      .p_colour    (p_colour),
      .p_wren      (p_wren),
      .p_done      (p_done),
      .b_x         (b_x),
      .b_y         (b_y),
      .b_colour    (b_colour),
      .b_wren      (b_wren),
      .b_done      (b_done),
      .move_en     (move_en),
      .p_draw      (p_draw),
      .b_draw      (b_draw),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .frame_done  (frame_done),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
         if (n_bad >= MAX_FAILS) begin
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
         end
      end
   endtask

   task automatic put_write(input int n, input int c, input bit [9:0] x, input bit [9:0] y,
                            input bit [2:0] col);
      if (c < n) begin
         e_plot[c] = 1'b1;
         e_x[c]    = x[7:0];
         e_y[c]    = y[6:0];
         e_col[c]  = col;
      end
   endtask

   // One frame sequence started by the tick in cycle t; returns its last busy cycle
   task automatic add_seq(input int n, input int t, input bit scripted, output int seq_end);
      int w1, w2, lp, lb, pd_at, bd_at, c;
      bit pto, bto;
      for (int i = 0; i < NCLR; i++) begin
         put_write(n, t + 2 + i, 10'(i % SW), 10'(i / SW), 3'b000);
      end
      if (scripted) begin
         pd_at = -1;
         bd_at = 9;
         if (t + NCLR + 2 < n) a_pd[t + NCLR + 2] = 1'b1;
      end else begin
         pd_at = int'($urandom_range(0, TO + 3));
         bd_at = int'($urandom_range(0, TO + 3));
      end
      pto = !(pd_at >= 0 && pd_at < TO);
      bto = !(bd_at >= 0 && bd_at < TO);
      lp  = pto ? TO : pd_at + 1;
      lb  = bto ? TO : bd_at + 1;
      w1  = t + NCLR + 3;
      w2  = w1 + lp + 1;
      if (t + NCLR + 1 < n) e_move[t + NCLR + 1] = 1'b1;
      if (t + NCLR + 2 < n) e_pdraw[t + NCLR + 2] = 1'b1;
      for (int j = 0; j < lp; j++) begin
         c = w1 + j;
         if (c < n) begin
            if (scripted) begin
               a_px[c] = 10'(32 + j);
               a_py[c] = 10'd110;
               a_pc[c] = 3'b100;
               a_pw[c] = 1'b1;
            end
            a_pd[c] = (j == pd_at);
            if (a_pw[c] && a_px[c] < 10'(SW) && a_py[c] < 10'(SH))
               put_write(n, c + 1, a_px[c], a_py[c], a_pc[c]);
         end
      end
      if (pto && w1 + TO < n) eto_ev[w1 + TO] = 1'b1;
      if (w1 + lp < n) e_bdraw[w1 + lp] = 1'b1;
      for (int j = 0; j < lb; j++) begin
         c = w2 + j;
         if (c < n) begin
            if (scripted && j < 4) begin
               a_bw[c] = 1'b1;
               case (j)
                  0: begin a_bx[c] = 10'd165; a_by[c] = 10'd50;  end
                  1: begin a_bx[c] = 10'd10;  a_by[c] = 10'd125; end
                  2: begin a_bx[c] = 10'd159; a_by[c] = 10'd119; end
                  default: begin a_bx[c] = 10'd160; a_by[c] = 10'd0; end
               endcase
            end
            a_bd[c] = (j == bd_at);
            if (a_bw[c] && a_bx[c] < 10'(SW) && a_by[c] < 10'(SH))
               put_write(n, c + 1, a_bx[c], a_by[c], a_bc[c]);
         end
      end
      if (bto && w2 + TO < n) eto_ev[w2 + TO] = 1'b1;
      if (w2 + lb < n) e_fdone[w2 + lb] = 1'b1;
      for (int k = t + 1; k <= w2 + lb && k < n; k++) e_busy[k] = 1'b1;
      seq_end = w2 + lb;
   endtask

   task automatic build(input int n, input int go_lo, input int go_hi, input bit scripted);
      int seq_end;
      bit eto_run, eov_run;
      seq_end = -1;
      for (int c = 0; c < n; c++) begin
         a_go[c] = !(c >= go_lo && c < go_hi);
         a_px[c] = 10'($urandom_range(0, 199));
         a_py[c] = 10'($urandom_range(0, 149));
         a_pc[c] = 3'($urandom);
         a_pw[c] = 1'($urandom);
         a_pd[c] = ($urandom_range(0, 7) == 0);
         a_bx[c] = 10'($urandom_range(0, 199));
         a_by[c] = 10'($urandom_range(0, 149));
         a_bc[c] = 3'($urandom);
         a_bw[c] = 1'($urandom);
         a_bd[c] = ($urandom_range(0, 7) == 0);
         e_plot[c] = 1'b0; e_move[c] = 1'b0; e_pdraw[c] = 1'b0; e_bdraw[c] = 1'b0;
         e_fdone[c] = 1'b0; e_busy[c] = 1'b0; eto_ev[c] = 1'b0;
         e_x[c] = '0; e_y[c] = '0; e_col[c] = '0;
      end
      for (int c = 0; c < n; c++) begin
         if (c % FD == FD - 1 && c > seq_end && a_go[c]) add_seq(n, c, scripted, seq_end);
      end
      eto_run = 1'b0;
      eov_run = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (eto_ev[c]) eto_run = 1'b1;
         e_eto[c] = eto_run;
         e_eov[c] = eov_run;
         if (c % FD == FD - 1 && e_busy[c]) eov_run = 1'b1;
      end
   endtask

   task automatic run(input int n);
      logic [31:0] obs, want;
      for (int c = 0; c < n; c++) begin
         go = a_go[c];
         p_x = a_px[c]; p_y = a_py[c]; p_colour = a_pc[c]; p_wren = a_pw[c]; p_done = a_pd[c];
         b_x = a_bx[c]; b_y = a_by[c]; b_colour = a_bc[c]; b_wren = a_bw[c]; b_done = a_bd[c];
         @(negedge clk);
         obs  = {6'd0, busy, move_en, p_draw, b_draw, frame_done, err_timeout, err_overrun,
                 vga_plot, vga_plot ? {vga_x, vga_y, vga_colour} : 18'd0};
         want = {6'd0, e_busy[c], e_move[c], e_pdraw[c], e_bdraw[c], e_fdone[c], e_eto[c],
                 e_eov[c], e_plot[c], e_plot[c] ? {e_x[c], e_y[c], e_col[c]} : 18'd0};
         check($sformatf("cyc%0d", c), obs, want);
         if (c < n - 1) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vga"}, 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'd0);
      check({tag, "_ctl"}, 32'({move_en, p_draw, b_draw, busy, frame_done}), 32'd0);
      check({tag, "_err"}, 32'({err_timeout, err_overrun}), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      go = 1'b0;
      p_x = '0; p_y = '0; p_colour = '0; p_wren = 1'b0; p_done = 1'b0;
      b_x = '0; b_y = '0; b_colour = '0; b_wren = 1'b0; b_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst");

      // First tick with go low is ignored; second starts a frame that reset cuts at (80,60)
      build(NA, 0, FD + 1, 1'b0);
      reset = 1'b0;
      run(NA);
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");

      // Full frame: platform times out, ball writes clipped points, next tick overruns
      build(NB, 25000, 30000, 1'b1);
      reset = 1'b0;
      run(NB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
